// File: rtl/divider_8x8_seq_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package divider_8x8_seq_pkg;

   localparam int DIV_W  = 8;                  // default operand/result width
   localparam int LANE_W = DIV_W / 2;          // lane width in dual-lane mode
   localparam int CNT_W  = $clog2(DIV_W + 1);  // iteration counter width

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/divider_8x8_seq_if.sv
// Start/Busy/Done handshake and operand/result bus of the divider.
// Signal prefixes are from the divider's point of view.
interface divider_8x8_seq_if #(
   parameter int W = divider_8x8_seq_pkg::DIV_W
);
   logic         i_start;
   logic [W-1:0] i_in_1;
   logic [W-1:0] i_in_2;
   logic         i_sign;
   logic         i_mode;
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_quotient;
   logic [W-1:0] o_remainder;
   logic [1:0]   o_div_by_zero;

   modport master (
      output i_start, i_in_1, i_in_2, i_sign, i_mode,
      input  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
   );

   modport slave (
      input  i_start, i_in_1, i_in_2, i_sign, i_mode,
      output o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
   );
endinterface

// File: rtl/divider_8x8_seq_div_restore_step.sv
// One restoring-division step for a single unsigned lane: shift the partial
// remainder left, bring in the next dividend bit, trial-subtract the divisor.
module div_restore_step #(
   parameter int LW = 4
) (
   input  logic [LW-1:0] i_rem,
   input  logic          i_bit,
   input  logic [LW-1:0] i_dvs,
   output logic [LW-1:0] o_rem,
   output logic          o_q
);
   logic [LW:0] w_shift;
   logic [LW:0] w_diff;

   // The partial remainder is always below the divisor, so the shifted value
   // fits in LW+1 bits and the MSB of the difference is its borrow.
   always_comb begin
      w_shift = {i_rem, i_bit};
      w_diff  = w_shift - {1'b0, i_dvs};
      o_q     = ~w_diff[LW];
      o_rem   = w_diff[LW] ? w_shift[LW-1:0] : w_diff[LW-1:0];
   end
endmodule

// File: rtl/divider_8x8_seq.sv
// Sequential restoring divider: one W-bit divide (mode 0) or two isolated
// W/2-bit divides (mode 1), one quotient bit per cycle, signed or unsigned.
module divider_8x8_seq #(
   parameter int W = divider_8x8_seq_pkg::DIV_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   divider_8x8_seq_if.slave  if_bus
);
   import divider_8x8_seq_pkg::*;

   localparam int LW = W / 2;

   // Magnitude of a full-width operand (absolute value only when signed).
   function automatic logic [W-1:0] mag_w(input logic [W-1:0] v, input logic s);
      return (s && v[W-1]) ? -v : v;
   endfunction

   // Magnitude of a lane operand.
   function automatic logic [LW-1:0] mag_l(input logic [LW-1:0] v, input logic s);
      return (s && v[LW-1]) ? -v : v;
   endfunction

   // Final lane quotient: all ones on divide-by-zero, else sign-corrected.
   function automatic logic [LW-1:0] fix_q_l(input logic [LW-1:0] q, input logic neg,
                                             input logic dbz);
      if (dbz) return '1;
      return neg ? -q : q;
   endfunction

   // Final lane remainder: original dividend on divide-by-zero, else signed like it.
   function automatic logic [LW-1:0] fix_r_l(input logic [LW-1:0] r, input logic [LW-1:0] orig,
                                             input logic neg, input logic dbz);
      if (dbz) return orig;
      return neg ? -r : r;
   endfunction

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_in;
   logic             r_mode;
   logic [W-1:0]     r_dvd;        // dividend magnitude, shifted out MSB-first; collects quotient bits
   logic [W-1:0]     r_dvs;        // divisor magnitude(s)
   logic [W-1:0]     r_rem;        // partial remainder(s)
   logic [W-1:0]     r_orig;       // original dividend bits for the divide-by-zero result
   logic [1:0]       r_neg_q;
   logic [1:0]       r_neg_r;
   logic [1:0]       r_dbz;
   logic [W-1:0]     r_quotient;
   logic [W-1:0]     r_remainder;
   logic [1:0]       r_div_by_zero;
   logic             r_done;

   logic [W-1:0]     w_dvd_in;
   logic [W-1:0]     w_dvs_in;
   logic [1:0]       w_neg_q_in;
   logic [1:0]       w_neg_r_in;
   logic [1:0]       w_dbz_in;
   logic [W-1:0]     w_rem_full;
   logic             w_q_full;
   logic [LW-1:0]    w_rem_l1;
   logic             w_q_l1;
   logic [LW-1:0]    w_rem_l0;
   logic             w_q_l0;
   logic [W-1:0]     w_fix_q;
   logic [W-1:0]     w_fix_r;
   logic             w_accept;

   assign w_accept = (r_state == ST_IDLE) && if_bus.i_start;

   div_restore_step #(.LW(W)) u_step_full (
      .i_rem (r_rem),
      .i_bit (r_dvd[W-1]),
      .i_dvs (r_dvs),
      .o_rem (w_rem_full),
      .o_q   (w_q_full)
   );

   div_restore_step #(.LW(LW)) u_step_l1 (
      .i_rem (r_rem[W-1:LW]),
      .i_bit (r_dvd[W-1]),
      .i_dvs (r_dvs[W-1:LW]),
      .o_rem (w_rem_l1),
      .o_q   (w_q_l1)
   );

   div_restore_step #(.LW(LW)) u_step_l0 (
      .i_rem (r_rem[LW-1:0]),
      .i_bit (r_dvd[LW-1]),
      .i_dvs (r_dvs[LW-1:0]),
      .o_rem (w_rem_l0),
      .o_q   (w_q_l0)
   );

   // Operand capture values: magnitudes, result-sign flags and zero-divisor flags per lane.
   always_comb begin
      w_dvd_in   = mag_w(if_bus.i_in_1, if_bus.i_sign);
      w_dvs_in   = mag_w(if_bus.i_in_2, if_bus.i_sign);
      w_neg_q_in = {1'b0, if_bus.i_sign & (if_bus.i_in_1[W-1] ^ if_bus.i_in_2[W-1])};
      w_neg_r_in = {1'b0, if_bus.i_sign & if_bus.i_in_1[W-1]};
      w_dbz_in   = {1'b0, (if_bus.i_in_2 == '0)};
      w_cnt_in   = CNT_W'(W);
      if (if_bus.i_mode) begin
         w_dvd_in   = {mag_l(if_bus.i_in_1[W-1:LW], if_bus.i_sign),
                       mag_l(if_bus.i_in_1[LW-1:0], if_bus.i_sign)};
         w_dvs_in   = {mag_l(if_bus.i_in_2[W-1:LW], if_bus.i_sign),
                       mag_l(if_bus.i_in_2[LW-1:0], if_bus.i_sign)};
         w_neg_q_in = {if_bus.i_sign & (if_bus.i_in_1[W-1]  ^ if_bus.i_in_2[W-1]),
                       if_bus.i_sign & (if_bus.i_in_1[LW-1] ^ if_bus.i_in_2[LW-1])};
         w_neg_r_in = {if_bus.i_sign & if_bus.i_in_1[W-1],
                       if_bus.i_sign & if_bus.i_in_1[LW-1]};
         w_dbz_in   = {(if_bus.i_in_2[W-1:LW] == '0), (if_bus.i_in_2[LW-1:0] == '0)};
         w_cnt_in   = CNT_W'(LW);
      end
   end

   // Sign correction and divide-by-zero override of the finished magnitudes.
   always_comb begin
      w_fix_q = r_neg_q[0] ? -r_dvd : r_dvd;
      w_fix_r = r_neg_r[0] ? -r_rem : r_rem;
      if (r_dbz[0]) begin
         w_fix_q = '1;
         w_fix_r = r_orig;
      end
      if (r_mode) begin
         w_fix_q = {fix_q_l(r_dvd[W-1:LW], r_neg_q[1], r_dbz[1]),
                    fix_q_l(r_dvd[LW-1:0], r_neg_q[0], r_dbz[0])};
         w_fix_r = {fix_r_l(r_rem[W-1:LW], r_orig[W-1:LW], r_neg_r[1], r_dbz[1]),
                    fix_r_l(r_rem[LW-1:0], r_orig[LW-1:0], r_neg_r[0], r_dbz[0])};
      end
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic: IDLE -> ITER (N edges) -> FIX (one edge) -> IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (if_bus.i_start) w_next_state = ST_ITER;
         ST_ITER: if (r_cnt == CNT_W'(1)) w_next_state = ST_FIX;
         ST_FIX:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Iteration counter, Done pulse and result registers; results change only at FIX.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt         <= '0;
         r_done        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= '0;
      end else begin
         r_done <= (r_state == ST_FIX);
         if (w_accept) begin
            r_cnt <= w_cnt_in;
         end else if (r_state == ST_ITER) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (r_state == ST_FIX) begin
            r_quotient    <= w_fix_q;
            r_remainder   <= w_fix_r;
            r_div_by_zero <= r_dbz;
         end
      end
   end

   // Datapath: load operands on accept, then one restoring step per ITER edge.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_mode  <= if_bus.i_mode;
         r_dvd   <= w_dvd_in;
         r_dvs   <= w_dvs_in;
         r_rem   <= '0;
         r_orig  <= if_bus.i_in_1;
         r_neg_q <= w_neg_q_in;
         r_neg_r <= w_neg_r_in;
         r_dbz   <= w_dbz_in;
      end else if (r_state == ST_ITER) begin
         if (r_mode) begin
            r_rem <= {w_rem_l1, w_rem_l0};
            r_dvd <= {r_dvd[W-2:LW], w_q_l1, r_dvd[LW-2:0], w_q_l0};
         end else begin
            r_rem <= w_rem_full;
            r_dvd <= {r_dvd[W-2:0], w_q_full};
         end
      end
   end

   assign if_bus.o_busy        = (r_state != ST_IDLE);
   assign if_bus.o_done        = r_done;
   assign if_bus.o_quotient    = r_quotient;
   assign if_bus.o_remainder   = r_remainder;
   assign if_bus.o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_divider_8x8_seq.sv
// Directed and random bench for divider_8x8_seq.
module tb_divider_8x8_seq;
   import divider_8x8_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   divider_8x8_seq_if bus_if ();

   divider_8x8_seq dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .if_bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive operands with Start for one edge; returns #1 after the start edge.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s, input logic m);
      bus_if.i_in_1  = a;
      bus_if.i_in_2  = b;
      bus_if.i_sign  = s;
      bus_if.i_mode  = m;
      bus_if.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus_if.i_start = 1'b0;
   endtask

   // Count edges until Done (bounded); bcnt counts Busy-high cycles before Done.
   task automatic wait_done(output int lat, output int bcnt);
      logic got;
      got  = 1'b0;
      lat  = 99;
      bcnt = (bus_if.o_busy === 1'b1) ? 1 : 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus_if.o_done === 1'b1) begin
            got = 1'b1;
            lat = k;
            break;
         end
         if (bus_if.o_busy === 1'b1) bcnt++;
      end
      chk("done_seen", {31'd0, got}, 32'd1);
   endtask

   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic m, input logic [7:0] eq,
                        input logic [7:0] er, input logic [1:0] ez, input int elat);
      int lat, bcnt;
      launch(a, b, s, m);
      wait_done(lat, bcnt);
      chk($sformatf("%s.q", tag), {24'd0, bus_if.o_quotient}, {24'd0, eq});
      chk($sformatf("%s.r", tag), {24'd0, bus_if.o_remainder}, {24'd0, er});
      chk($sformatf("%s.dbz", tag), {30'd0, bus_if.o_div_by_zero}, {30'd0, ez});
      if (elat > 0) chk($sformatf("%s.lat", tag), lat, elat);
   endtask

   // Golden truncating division for one lane of width lw.
   function automatic void lane_model(input int lw, input int a, input int b, input logic s,
                                      output int q, output int r, output logic z);
      int sa, sb, mask;
      mask = (1 << lw) - 1;
      if (b == 0) begin
         q = mask;
         r = a;
         z = 1'b1;
      end else begin
         sa = (s && a >= (1 << (lw - 1))) ? a - (1 << lw) : a;
         sb = (s && b >= (1 << (lw - 1))) ? b - (1 << lw) : b;
         q  = (sa / sb) & mask;
         r  = (sa % sb) & mask;
         z  = 1'b0;
      end
   endfunction

   function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 input logic m, output logic [7:0] eq, output logic [7:0] er,
                                 output logic [1:0] ez);
      int q1, r1, q0, r0;
      logic z1, z0;
      if (!m) begin
         lane_model(8, int'(a), int'(b), s, q0, r0, z0);
         eq = q0[7:0];
         er = r0[7:0];
         ez = {1'b0, z0};
      end else begin
         lane_model(4, int'(a[7:4]), int'(b[7:4]), s, q1, r1, z1);
         lane_model(4, int'(a[3:0]), int'(b[3:0]), s, q0, r0, z0);
         eq = {q1[3:0], q0[3:0]};
         er = {r1[3:0], r0[3:0]};
         ez = {z1, z0};
      end
   endfunction

   initial begin
      int lat, bcnt, seen;
      logic [7:0] ra, rb, eq, er;
      logic [1:0] ez;
      logic rs, rm;

      rst = 1'b1;
      bus_if.i_start = 1'b0;
      bus_if.i_in_1  = 8'h00;
      bus_if.i_in_2  = 8'h00;
      bus_if.i_sign  = 1'b0;
      bus_if.i_mode  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", {31'd0, bus_if.o_busy}, 32'd0);
      chk("rst.done", {31'd0, bus_if.o_done}, 32'd0);
      chk("rst.q", {24'd0, bus_if.o_quotient}, 32'd0);
      chk("rst.r", {24'd0, bus_if.o_remainder}, 32'd0);
      chk("rst.dbz", {30'd0, bus_if.o_div_by_zero}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Unsigned 200/7 with latency and Busy duration
      launch(8'd200, 8'd7, 1'b0, 1'b0);
      wait_done(lat, bcnt);
      chk("u200_7.lat", lat, 9);
      chk("u200_7.busy_cycles", bcnt, 9);
      chk("u200_7.busy_at_done", {31'd0, bus_if.o_busy}, 32'd0);
      chk("u200_7.q", {24'd0, bus_if.o_quotient}, 32'd28);
      chk("u200_7.r", {24'd0, bus_if.o_remainder}, 32'd4);
      chk("u200_7.dbz", {30'd0, bus_if.o_div_by_zero}, 32'd0);

      // Start accepted in the Done cycle: 100/9 = 11 r 1
      launch(8'd100, 8'd9, 1'b0, 1'b0);
      wait_done(lat, bcnt);
      chk("b2b.lat", lat, 9);
      chk("b2b.q", {24'd0, bus_if.o_quotient}, 32'h0B);
      chk("b2b.r", {24'd0, bus_if.o_remainder}, 32'h01);
      @(posedge clk);
      #1;
      chk("b2b.done_pulse", {31'd0, bus_if.o_done}, 32'd0);
      chk("b2b.q_held", {24'd0, bus_if.o_quotient}, 32'h0B);

      // Signed cases and signed overflow
      do_op("s_m100_7", 8'h9C, 8'h07, 1'b1, 1'b0, 8'hF2, 8'hFE, 2'b00, 9);
      do_op("s_ovf", 8'h80, 8'hFF, 1'b1, 1'b0, 8'h80, 8'h00, 2'b00, 9);

      // Divide by zero, unsigned and signed
      do_op("dbz_u", 8'h55, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h55, 2'b01, 9);
      do_op("dbz_s", 8'h55, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h55, 2'b01, 9);

      // Dual-lane signed: 7/2 and -5/3
      launch(8'h7B, 8'h23, 1'b1, 1'b1);
      wait_done(lat, bcnt);
      chk("dual_s.lat", lat, 5);
      chk("dual_s.busy_cycles", bcnt, 5);
      chk("dual_s.q", {24'd0, bus_if.o_quotient}, 32'h3F);
      chk("dual_s.r", {24'd0, bus_if.o_remainder}, 32'h1E);
      chk("dual_s.dbz", {30'd0, bus_if.o_div_by_zero}, 32'd0);

      // Dual-lane, lane0 divisor zero; Start and operand changes mid-ITER ignored
      launch(8'h7B, 8'h30, 1'b0, 1'b1);
      bus_if.i_in_1  = 8'h11;
      bus_if.i_in_2  = 8'h11;
      bus_if.i_sign  = 1'b1;
      bus_if.i_mode  = 1'b0;
      bus_if.i_start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus_if.i_start = 1'b0;
      wait_done(lat, bcnt);
      chk("dual_dbz.lat", lat, 3);
      chk("dual_dbz.q", {24'd0, bus_if.o_quotient}, 32'h2F);
      chk("dual_dbz.r", {24'd0, bus_if.o_remainder}, 32'h1B);
      chk("dual_dbz.dbz", {30'd0, bus_if.o_div_by_zero}, 32'h1);

      // Reset mid-ITER clears outputs at once and suppresses Done
      launch(8'hF0, 8'h03, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst.busy", {31'd0, bus_if.o_busy}, 32'd0);
      chk("mid_rst.done", {31'd0, bus_if.o_done}, 32'd0);
      chk("mid_rst.q", {24'd0, bus_if.o_quotient}, 32'd0);
      chk("mid_rst.r", {24'd0, bus_if.o_remainder}, 32'd0);
      chk("mid_rst.dbz", {30'd0, bus_if.o_div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus_if.o_done === 1'b1) seen++;
      end
      chk("mid_rst.no_done", seen, 0);
      do_op("after_rst", 8'hF0, 8'h03, 1'b0, 1'b0, 8'h50, 8'h00, 2'b00, 9);

      // Random operands over all Sign/Mode combinations
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if (i % 16 == 3) rb = 8'h00;
         if (i % 16 == 7) rb[3:0] = 4'h0;
         if (i % 16 == 11) begin
            ra = 8'h88;
            rb = 8'hFF;
         end
         rs = i[0];
         rm = i[1];
         model(ra, rb, rs, rm, eq, er, ez);
         do_op($sformatf("rnd%0d", i), ra, rb, rs, rm, eq, er, ez, rm ? 5 : 9);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
